// File: rtl/dpram_port_arbiter.sv
// ---------------------------------------------------------------------------
// dpram_port_arbiter
//   Shares one synchronous RAM port (1-cycle read latency, write-through)
//   between two requesters, m0 and m1.
//
//   Arbitration is round-robin (RR=1) or fixed priority with m0 highest
//   (RR=0). A requester may lock the grant across several transfers. Read
//   data is returned to whichever requester issued the read, one cycle
//   after the transfer.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   mX_req/we/lock/addr/wdata     request and its fields (X = 0, 1), held
//                                 stable until acked
//   mX_ack                        request accepted this cycle (combinational)
//   mX_rdata, mX_rvalid           read return; rdata is a pass-through of
//                                 ram_read, rvalid is registered
//   ram_ce/we/addr/write          RAM port drive (combinational)
//   ram_read                      RAM read data, valid 1 cycle after a read
// ---------------------------------------------------------------------------
module dpram_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int RR     = 1
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,

    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_write,
    input  logic [DATA_W-1:0] ram_read
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCK0    = 2'd1,
        LOCK1    = 2'd2
    } lock_state_t;

    lock_state_t state_r;
    logic        last_r;        // requester of the last transfer: 0 = m0, 1 = m1
    logic        rvalid0_r;
    logic        rvalid1_r;

    logic        gnt0_s;
    logic        gnt1_s;
    logic        xfer0_s;
    logic        xfer1_s;

    // Grant decision from current requests and registered lock/last state.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!reset_n) begin
            // Nothing is granted while reset is held, regardless of requests.
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                UNLOCKED: begin
                    if (m0_req && m1_req) begin
                        if (RR != 0) begin
                            // Favour the requester that did not win last time.
                            gnt0_s = last_r;
                            gnt1_s = ~last_r;
                        end else begin
                            gnt0_s = 1'b1;
                        end
                    end else begin
                        gnt0_s = m0_req;
                        gnt1_s = m1_req;
                    end
                end
                // While locked the other requester is shut out even if the
                // owner idles; the owner idling releases the lock below.
                LOCK0:   gnt0_s = m0_req;
                LOCK1:   gnt1_s = m1_req;
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    assign xfer0_s = m0_req & gnt0_s;
    assign xfer1_s = m1_req & gnt1_s;

    // Mux the granted requester's fields onto the RAM port; zero when idle.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_write = {DATA_W{1'b0}};
        if (gnt0_s) begin
            ram_we    = m0_we;
            ram_addr  = m0_addr;
            ram_write = m0_wdata;
        end else if (gnt1_s) begin
            ram_we    = m1_we;
            ram_addr  = m1_addr;
            ram_write = m1_wdata;
        end else begin
            ram_we    = 1'b0;
            ram_addr  = {ADDR_W{1'b0}};
            ram_write = {DATA_W{1'b0}};
        end
    end

    assign m0_ack    = gnt0_s;
    assign m1_ack    = gnt1_s;
    assign ram_ce    = gnt0_s | gnt1_s;
    assign m0_rdata  = ram_read;
    assign m1_rdata  = ram_read;
    assign m0_rvalid = rvalid0_r;
    assign m1_rvalid = rvalid1_r;

    // Lock FSM, last-winner pointer and read-return tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= UNLOCKED;
            last_r    <= 1'b1;      // m0 wins the first contention
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
        end else begin
            rvalid0_r <= xfer0_s & ~m0_we;
            rvalid1_r <= xfer1_s & ~m1_we;

            if (xfer0_s) begin
                last_r <= 1'b0;
            end else if (xfer1_s) begin
                last_r <= 1'b1;
            end else begin
                last_r <= last_r;
            end

            case (state_r)
                UNLOCKED: begin
                    if (xfer0_s && m0_lock) begin
                        state_r <= LOCK0;
                    end else if (xfer1_s && m1_lock) begin
                        state_r <= LOCK1;
                    end else begin
                        state_r <= UNLOCKED;
                    end
                end
                LOCK0: begin
                    if (!m0_req || (xfer0_s && !m0_lock)) begin
                        state_r <= UNLOCKED;
                    end else begin
                        state_r <= LOCK0;
                    end
                end
                LOCK1: begin
                    if (!m1_req || (xfer1_s && !m1_lock)) begin
                        state_r <= UNLOCKED;
                    end else begin
                        state_r <= LOCK1;
                    end
                end
                default: state_r <= UNLOCKED;
            endcase
        end
    end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Shares one synchronous RAM port (12-bit address, 16-bit data, 1-cycle read latency, write-through) between two requesters, m0 and m1.
- Sits in front of port A or port B of the dual-port RAM.
- Provides a req/ack handshake per requester, round-robin or fixed-priority arbitration, an optional burst lock, and routing of read data back to the requester that issued the read.

Parameters:
ADDR_W, 12, address width
DATA_W, 16, data width
RR, 1, 1 = round-robin arbitration; 0 = fixed priority with m0 highest

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous reset, active-low
m0_req  in  1  m0 access request; held with its fields until acked
m0_we  in  1  1 = write, 0 = read
m0_lock  in  1  keep the grant after this transfer
m0_addr  in  ADDR_W  m0 address
m0_wdata  in  DATA_W  m0 write data
m0_ack  out  1  m0 request accepted this cycle
m0_rdata  out  DATA_W  read data to m0
m0_rvalid  out  1  m0_rdata valid
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_rvalid  same widths and meaning as the m0 ports, for m1
ram_ce  out  1  RAM port enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_write  out  DATA_W  RAM write data
ram_read  in  DATA_W  RAM read data, valid 1 cycle after a read access

Behaviour:
- Transfer: a transfer occurs in cycle t when mX_req=1 and mX_ack=1; the RAM samples it at the edge ending cycle t.
- Ack and RAM outputs are combinational from the requests and the registered arbiter state.
  - Only the granted requester's ack is 1.
  - ram_ce = OR of the acks.
  - ram_we, ram_addr, ram_write = granted requester's fields; all zero when nothing is granted.
- Grant with no lock active:
  - Only one requester requesting: it is granted.
  - Both requesting, RR=1: grant the requester not granted in the last transfer (last pointer).
  - Both requesting, RR=0: m0 is granted.
- Last pointer: updates on every transfer; reset value = m1, so m0 wins the first contention.
- Lock state machine, states UNLOCKED, LOCK0, LOCK1:
  - UNLOCKED -> LOCKx on a transfer by mX with mX_lock=1.
  - In LOCKx, only mX can be granted; the other requester's ack stays 0 even if mX idles.
  - LOCKx -> UNLOCKED on a transfer by mX with mX_lock=0.
  - LOCKx -> UNLOCKED in any cycle where mX_req=0; the other requester becomes grantable from the next cycle.
  - In LOCKx, a transfer with mX_lock=1 stays in LOCKx.
- Read return:
  - A read transfer in cycle t sets mX_rvalid=1 in cycle t+1 for exactly 1 cycle.
  - mX_rdata is a pass-through of ram_read and is meaningful only when mX_rvalid=1.
  - Writes produce no rvalid.
  - Back-to-back reads by alternating requesters give alternating rvalid pulses with no bubble.
- Throughput: one transfer per cycle; no wait state between transfers.
- Reset (asynchronous, any time):
  - State -> UNLOCKED, last pointer = m1, m0_rvalid = m1_rvalid = 0.
  - While reset_n=0: both acks = 0, ram_ce = ram_we = 0, ram_addr = ram_write = 0.
  - A read in flight at reset assertion is discarded; no rvalid after release.
- Held requests: an unacked request is not dropped; the requester keeps req and its fields stable. Starvation-free under RR=1 without lock.

Test Plan:
- m0 writes 0xBEEF to addr 0x123, then reads 0x123 -> write cycle: m0_ack=1, ram_we=1, ram_addr=0x123, ram_write=0xBEEF; read cycle t: m0_ack=1, ram_we=0; cycle t+1: m0_rvalid=1, m0_rdata=0xBEEF, m1_rvalid=0.
- RR=1, both hold read requests (m0 addr 0x001, m1 addr 0x002) for 4 cycles after reset -> grants m0, m1, m0, m1; rvalid alternates m0, m1, m0, m1 one cycle later; data matches the preloaded words.
- RR=0, both requesting continuously -> m0_ack=1 every cycle; m1_ack stays 0 until m0_req=0, then m1 is granted the same cycle.
- Lock: m1 does 3 writes to 0x010..0x012, lock=1, 1, 0, while m0 requests throughout -> m1 acked 3 consecutive cycles; m0 acked in the 4th cycle. Repeat with m1 dropping req after the 1st write -> m0 acked the cycle after the drop.
- Reset mid-read: pulse reset_n=0 in the cycle after an m0 read transfer -> m0_rvalid stays 0, ram_ce=0 during reset; first contention after release grants m0.
